cache_sram_arbiter: RTL and testbench

//  Merges the i_cache and d_cache SRAM-like miss/write-through ports into one SRAM-like port feeding the

---
 rtl/cache_sram_arbiter_pkg.sv | 17 +
 rtl/cache_sram_arbiter_if.sv | 27 ++
 rtl/cache_sram_arbiter_order_fifo.sv | 76 +++++++
 rtl/cache_sram_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_sram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_sram_arbiter_pkg.sv
// Shared constants for the cache-to-bridge SRAM arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package cache_arb_pkg;

  // Requester identity carried through the order FIFO
  typedef logic arb_id_t;

  localparam arb_id_t ID_INST = 1'b0;
  localparam arb_id_t ID_DATA = 1'b1;

  // SRAM-like transfer sizes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cache_sram_arbiter_if.sv
// SRAM-like request/response port shared by caches and the AXI bridge.
// Latency: none (wires only).
// Backpressure: master holds req and its fields until addr_ok; data_ok is never stalled.
interface cache_sram_arbiter_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  // Side that issues requests
  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  // Side that accepts requests
  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );

endinterface

// File: rtl/cache_sram_arbiter_order_fifo.sv
// Order FIFO remembering which requester owns each outstanding bus request.
// Latency: push visible at head the cycle after; pop/push same cycle allowed when full.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module arb_order_fifo
  import cache_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  arb_id_t          push_dat,
  input  logic             pop,
  output arb_id_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state: pop frees the head slot first, so a full FIFO can take a push alongside it
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops every outstanding entry
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cache_sram_arbiter.sv
// Merges i_cache and d_cache SRAM-like ports onto the single bridge port, routing responses in order.
// Latency: zero added cycles on address phase and on data_ok/rdata return.
// Backpressure: bus_req held low while MAX_OUTSTANDING requests are unanswered (unless one retires now).
module cache_sram_arbiter
  import cache_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_sram_arbiter_if.slave   inst,
  cache_sram_arbiter_if.slave   data,
  cache_sram_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             grant_valid_q, grant_valid_d;
  arb_id_t          grant_id_q, grant_id_d;
  arb_id_t          last_id_q, last_id_d;

  logic             sel_vld;
  arb_id_t          sel_id;
  logic             sel_req;
  logic             fifo_block;
  logic             bus_hs;
  logic             resp_vld;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  arb_id_t          fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Requester selection: a held grant wins, otherwise round-robin against the last winner
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = ID_INST;
    if (grant_valid_q) begin
      sel_vld = 1'b1;
      sel_id  = grant_id_q;
    end else if (inst.req && data.req) begin
      sel_vld = 1'b1;
      sel_id  = (last_id_q == ID_INST) ? ID_DATA : ID_INST;
    end else if (data.req) begin
      sel_vld = 1'b1;
      sel_id  = ID_DATA;
    end else if (inst.req) begin
      sel_vld = 1'b1;
      sel_id  = ID_INST;
    end
  end

  assign sel_req    = sel_vld && ((sel_id == ID_DATA) ? data.req : inst.req);
  // A response retiring this cycle frees a slot, so a full FIFO does not block then
  assign fifo_block = (fifo_count == CNT_W'(MAX_OUTSTANDING)) && !bus.data_ok;

  // Bus request mux; fields read as zero when nobody is selected
  always_comb begin
    bus.req   = sel_req && !fifo_block && !rst;
    bus.wr    = 1'b0;
    bus.size  = 2'd0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    if (sel_vld) begin
      if (sel_id == ID_DATA) begin
        bus.wr    = data.wr;
        bus.size  = data.size;
        bus.addr  = data.addr;
        bus.wdata = data.wdata;
      end else begin
        bus.wr    = inst.wr;
        bus.size  = inst.size;
        bus.addr  = inst.addr;
        bus.wdata = inst.wdata;
      end
    end
  end

  assign bus_hs       = bus.req && bus.addr_ok;
  assign inst.addr_ok = bus_hs && (sel_id == ID_INST);
  assign data.addr_ok = bus_hs && (sel_id == ID_DATA);

  // A data_ok with nothing outstanding is dropped rather than misrouted
  assign resp_vld     = bus.data_ok && !fifo_empty && !rst;
  assign fifo_pop     = resp_vld;
  assign fifo_push    = bus_hs && (!fifo_full || fifo_pop);
  assign inst.data_ok = resp_vld && (fifo_head == ID_INST);
  assign data.data_ok = resp_vld && (fifo_head == ID_DATA);
  assign inst.rdata   = bus.rdata;
  assign data.rdata   = bus.rdata;

  // Grant tracking: release on handshake, otherwise lock onto the pending requester
  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_id_d     = last_id_q;
    if (bus_hs) begin
      grant_valid_d = 1'b0;
      last_id_d     = sel_id;
    end else if (sel_req) begin
      grant_valid_d = 1'b1;
      grant_id_d    = sel_id;
    end
  end

  // Grant state registers; last_id resets to INST so DATA wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_valid_q <= 1'b0;
      grant_id_q    <= ID_INST;
      last_id_q     <= ID_INST;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_id_q     <= last_id_d;
    end
  end

  arb_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (sel_id),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_cache_sram_arbiter.sv
// Self-checking bench for cache_sram_arbiter with an in-order response scoreboard.
// Latency: bench drives #1 after rising edge, samples on falling edge.
// Backpressure: bridge addr_ok/data_ok scripted per scenario.
module tb_cache_sram_arbiter;
  import cache_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_sram_arbiter_if inst_if ();
  cache_sram_arbiter_if data_if ();
  cache_sram_arbiter_if bus_if ();

  cache_sram_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if.slave),
    .data (data_if.slave),
    .bus  (bus_if.master)
  );

  typedef struct {
    arb_id_t     id;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   inst_resp_cnt = 0;
  int   data_resp_cnt = 0;

  exp_t        mon_exp;
  arb_id_t     mon_id;
  logic [31:0] mon_rd;

  // Response monitor: every data_ok must match the next expected entry
  always @(negedge clk) begin
    if (inst_if.data_ok || data_if.data_ok) begin
      checks++;
      if (inst_if.data_ok) inst_resp_cnt++;
      if (data_if.data_ok) data_resp_cnt++;
      mon_id = data_if.data_ok ? ID_DATA : ID_INST;
      mon_rd = data_if.data_ok ? data_if.rdata : inst_if.rdata;
      if (inst_if.data_ok && data_if.data_ok) begin
        errors++;
        $display("FAIL resp_both: inst_data_ok and data_data_ok both 1, required one");
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: data_ok on id %0d, required no response", mon_id);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_id !== mon_exp.id || mon_rd !== mon_exp.rdata) begin
          errors++;
          $display("FAIL resp_route: got id %0d rdata %h, required id %0d rdata %h",
                   mon_id, mon_rd, mon_exp.id, mon_exp.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0; data_if.wdata = 0;
    bus_if.addr_ok = 0; bus_if.data_ok = 0; bus_if.rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    inst_if.req = 1; data_if.req = 1; bus_if.addr_ok = 1; bus_if.data_ok = 1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (bus_if.req !== 1'b0) begin
      errors++; $display("FAIL reset_bus_req: got %b required 0", bus_if.req);
    end
    checks++;
    if ({inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 4'b0) begin
      errors++;
      $display("FAIL reset_oks: got %b required 0000",
               {inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok});
    end
    step();
    clear_inputs();
    rst = 0;
    @(negedge clk);
    checks++;
    if (dut.fifo_count !== 2'd0 || bus_if.req !== 1'b0) begin
      errors++; $display("FAIL reset_state: count %0d bus_req %b required 0 0", dut.fifo_count, bus_if.req);
    end
  endtask

  task automatic test_single_inst();
    int i0, d0;
    do_reset();
    i0 = inst_resp_cnt; d0 = data_resp_cnt;
    inst_if.req = 1; inst_if.size = SIZE_WORD; inst_if.addr = 32'hBFC00000;
    bus_if.addr_ok = 1;
    sb_q.push_back('{ID_INST, 32'h3C1A0001});
    @(negedge clk);
    checks++;
    if ({bus_if.req, inst_if.addr_ok, data_if.addr_ok} !== 3'b110 || bus_if.addr !== 32'hBFC00000 ||
        bus_if.size !== SIZE_WORD || bus_if.wr !== 1'b0) begin
      errors++;
      $display("FAIL single_addr: req/iok/dok %b addr %h size %0d wr %b required 110 bfc00000 2 0",
               {bus_if.req, inst_if.addr_ok, data_if.addr_ok}, bus_if.addr, bus_if.size, bus_if.wr);
    end
    step();
    inst_if.req = 0; bus_if.addr_ok = 0;
    step();
    step();
    bus_if.data_ok = 1; bus_if.rdata = 32'h3C1A0001;
    step();
    bus_if.data_ok = 0;
    step();
    checks++;
    if (inst_resp_cnt - i0 != 1 || data_resp_cnt - d0 != 0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL single_resp: inst %0d data %0d pending %0d required 1 0 0",
               inst_resp_cnt - i0, data_resp_cnt - d0, sb_q.size());
    end
  endtask

  task automatic test_tie_break();
    do_reset();
    inst_if.req = 1; inst_if.size = SIZE_WORD; inst_if.addr = 32'hBFC00010;
    data_if.req = 1; data_if.size = SIZE_WORD; data_if.addr = 32'h80001000;
    bus_if.addr_ok = 1;
    sb_q.push_back('{ID_DATA, 32'h11});
    sb_q.push_back('{ID_INST, 32'h22});
    @(negedge clk);
    checks++;
    if (bus_if.addr !== 32'h80001000 || {data_if.addr_ok, inst_if.addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL tie_first: addr %h d/i ok %b required 80001000 10",
               bus_if.addr, {data_if.addr_ok, inst_if.addr_ok});
    end
    step();
    data_if.req = 0;
    @(negedge clk);
    checks++;
    if (bus_if.addr !== 32'hBFC00010 || {data_if.addr_ok, inst_if.addr_ok} !== 2'b01) begin
      errors++;
      $display("FAIL tie_second: addr %h d/i ok %b required bfc00010 01",
               bus_if.addr, {data_if.addr_ok, inst_if.addr_ok});
    end
    step();
    inst_if.req = 0; bus_if.addr_ok = 0;
    bus_if.data_ok = 1; bus_if.rdata = 32'h11;
    step();
    bus_if.rdata = 32'h22;
    step();
    bus_if.data_ok = 0;
    step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL tie_pending: got %0d required 0", sb_q.size());
    end
  endtask

  task automatic test_grant_lock();
    do_reset();
    inst_if.req = 1; inst_if.size = SIZE_WORD; inst_if.addr = 32'hBFC00020;
    data_if.size = SIZE_WORD; data_if.addr = 32'h80002000;
    bus_if.addr_ok = 0;
    sb_q.push_back('{ID_INST, 32'h33});
    sb_q.push_back('{ID_DATA, 32'h44});
    for (int c = 0; c < 4; c++) begin
      if (c == 1) data_if.req = 1;
      @(negedge clk);
      checks++;
      if (bus_if.req !== 1'b1 || bus_if.addr !== 32'hBFC00020 ||
          {inst_if.addr_ok, data_if.addr_ok} !== 2'b00) begin
        errors++;
        $display("FAIL lock_stall c%0d: req %b addr %h i/d ok %b required 1 bfc00020 00",
                 c, bus_if.req, bus_if.addr, {inst_if.addr_ok, data_if.addr_ok});
      end
      step();
    end
    bus_if.addr_ok = 1;
    @(negedge clk);
    checks++;
    if (bus_if.addr !== 32'hBFC00020 || {inst_if.addr_ok, data_if.addr_ok} !== 2'b10) begin
      errors++;
      $display("FAIL lock_inst_hs: addr %h i/d ok %b required bfc00020 10",
               bus_if.addr, {inst_if.addr_ok, data_if.addr_ok});
    end
    step();
    inst_if.req = 0;
    @(negedge clk);
    checks++;
    if (bus_if.addr !== 32'h80002000 || {inst_if.addr_ok, data_if.addr_ok} !== 2'b01) begin
      errors++;
      $display("FAIL lock_data_hs: addr %h i/d ok %b required 80002000 01",
               bus_if.addr, {inst_if.addr_ok, data_if.addr_ok});
    end
    step();
    data_if.req = 0; bus_if.addr_ok = 0;
    bus_if.data_ok = 1; bus_if.rdata = 32'h33;
    step();
    bus_if.rdata = 32'h44;
    step();
    bus_if.data_ok = 0;
    step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL lock_pending: got %0d required 0", sb_q.size());
    end
  endtask

  task automatic test_full_fifo();
    do_reset();
    bus_if.addr_ok = 1;
    sb_q.push_back('{ID_INST, 32'h55});
    sb_q.push_back('{ID_DATA, 32'h66});
    sb_q.push_back('{ID_INST, 32'h77});
    inst_if.req = 1; inst_if.addr = 32'hBFC00030;
    step();
    inst_if.req = 0; data_if.req = 1; data_if.addr = 32'h80003000;
    step();
    data_if.req = 0; inst_if.req = 1; inst_if.addr = 32'hBFC00040;
    @(negedge clk);
    checks++;
    if (bus_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0 || dut.fifo_count !== 2'd2) begin
      errors++;
      $display("FAIL full_block: bus_req %b inst_addr_ok %b count %0d required 0 0 2",
               bus_if.req, inst_if.addr_ok, dut.fifo_count);
    end
    step();
    bus_if.data_ok = 1; bus_if.rdata = 32'h55;
    @(negedge clk);
    checks++;
    if (bus_if.req !== 1'b1 || inst_if.addr_ok !== 1'b1 || bus_if.addr !== 32'hBFC00040) begin
      errors++;
      $display("FAIL full_swap: bus_req %b inst_addr_ok %b addr %h required 1 1 bfc00040",
               bus_if.req, inst_if.addr_ok, bus_if.addr);
    end
    step();
    inst_if.req = 0; bus_if.addr_ok = 0;
    bus_if.rdata = 32'h66;
    @(negedge clk);
    checks++;
    if (dut.fifo_count !== 2'd2) begin
      errors++; $display("FAIL full_count: got %0d required 2", dut.fifo_count);
    end
    step();
    bus_if.rdata = 32'h77;
    step();
    bus_if.data_ok = 0;
    step();
    checks++;
    if (sb_q.size() != 0 || dut.fifo_count !== 2'd0) begin
      errors++;
      $display("FAIL full_drain: pending %0d count %0d required 0 0", sb_q.size(), dut.fifo_count);
    end
  endtask

  task automatic test_data_write();
    int i0, d0;
    do_reset();
    i0 = inst_resp_cnt; d0 = data_resp_cnt;
    data_if.req = 1; data_if.wr = 1; data_if.size = SIZE_BYTE;
    data_if.addr = 32'h80000003; data_if.wdata = 32'h000000AB;
    bus_if.addr_ok = 1;
    sb_q.push_back('{ID_DATA, 32'h0});
    @(negedge clk);
    checks++;
    if ({bus_if.req, bus_if.wr} !== 2'b11 || bus_if.size !== SIZE_BYTE ||
        bus_if.addr !== 32'h80000003 || bus_if.wdata !== 32'h000000AB || data_if.addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL write_fields: req/wr %b size %0d addr %h wdata %h dok %b required 11 0 80000003 000000ab 1",
               {bus_if.req, bus_if.wr}, bus_if.size, bus_if.addr, bus_if.wdata, data_if.addr_ok);
    end
    step();
    data_if.req = 0; data_if.wr = 0; bus_if.addr_ok = 0;
    bus_if.data_ok = 1; bus_if.rdata = 32'h0;
    step();
    bus_if.data_ok = 0;
    step();
    checks++;
    if (data_resp_cnt - d0 != 1 || inst_resp_cnt - i0 != 0) begin
      errors++;
      $display("FAIL write_resp: data %0d inst %0d required 1 0", data_resp_cnt - d0, inst_resp_cnt - i0);
    end
  endtask

  task automatic test_reset_outstanding();
    do_reset();
    bus_if.addr_ok = 1;
    inst_if.req = 1; inst_if.addr = 32'hBFC00050;
    step();
    inst_if.req = 0; data_if.req = 1; data_if.addr = 32'h80005000;
    step();
    data_if.req = 0; bus_if.addr_ok = 0;
    @(negedge clk);
    checks++;
    if (dut.fifo_count !== 2'd2) begin
      errors++; $display("FAIL rstout_pre: count %0d required 2", dut.fifo_count);
    end
    step();
    rst = 1; inst_if.req = 1; bus_if.addr_ok = 1;
    @(negedge clk);
    checks++;
    if (bus_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL rstout_gate: bus_req %b inst_addr_ok %b required 0 0", bus_if.req, inst_if.addr_ok);
    end
    step();
    rst = 0; inst_if.req = 0; bus_if.addr_ok = 0;
    @(negedge clk);
    checks++;
    if (dut.fifo_count !== 2'd0) begin
      errors++; $display("FAIL rstout_count: count %0d required 0", dut.fifo_count);
    end
    step();
    bus_if.data_ok = 1; bus_if.rdata = 32'h99;
    @(negedge clk);
    checks++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin
      errors++;
      $display("FAIL rstout_stray: i/d data_ok %b required 00", {inst_if.data_ok, data_if.data_ok});
    end
    step();
    bus_if.data_ok = 0;
    step();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single_inst();
    test_tie_break();
    test_grant_lock();
    test_full_fifo();
    test_data_write();
    test_reset_outstanding();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
